rx_udp_packer: RTL and testbench

//  Downstream of the UDP receive stage, on RX_CLK. Consumes the UDP payload byte stream
//  (rx_udp_data_v / rx_udp_data) and packs it little-endian into 32-bit words written to
//  the RX SRAM. On frame end it reports the byte count, raises a done pulse and holds the

---
 rtl/vthernet_pkg.sv | 39 +++
 rtl/rx_byte_packer.sv | 60 ++++++
 rtl/rx_udp_packer.sv | 251 +++++++++++++++++++++++++
 tb/tb_rx_udp_packer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vthernet_pkg.sv
// vthernet_pkg: shared types and helpers for the RX payload packer.
// Holds the FSM state encoding, the byte width and the lane-mask helpers.
package vthernet_pkg;

    localparam int OCT = 8;

    localparam logic [3:0] FULL_MASK = 4'b1111;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_RECV,
        ST_FLUSH,
        ST_HOLD,
        ST_DROP
    } rx_state_e;

    // Byte-lane enables for a partial word holding 'lanes' bytes.
    function automatic logic [3:0] lane_mask(input logic [1:0] lanes);
        logic [3:0] m;
        case (lanes)
            2'd0:    m = 4'b0000;
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            default: m = 4'b0111;
        endcase
        return m;
    endfunction

    // Expand a 4-bit lane mask into a 32-bit data mask.
    function automatic logic [31:0] mask_to_bits(input logic [3:0] m);
        logic [31:0] b;
        for (int i = 0; i < 4; i++) begin
            b[i*OCT +: OCT] = {OCT{m[i]}};
        end
        return b;
    endfunction

endpackage

// File: rtl/rx_byte_packer.sv
// rx_byte_packer: lane counter and little-endian assembler for 32-bit words.
// Ports: clk/rst_n (sync, active-low); start forces the next byte into lane 0;
//   byte_v/byte_in accept one byte; lanes = bytes pending; word_rdy/word give
//   a completed word in the cycle its 4th byte is accepted; part_data/part_mask
//   describe the pending partial word with unused lanes zeroed.
module rx_byte_packer
    import vthernet_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_v,
    input  logic [7:0]  byte_in,
    output logic [1:0]  lanes,
    output logic        word_rdy,
    output logic [31:0] word,
    output logic [31:0] part_data,
    output logic [3:0]  part_mask
);

    logic [1:0]  lane_q;
    logic [1:0]  lane_d;
    logic [1:0]  cur_lane;
    logic [23:0] acc_q;
    logic [23:0] acc_d;

    always_comb begin
        cur_lane = start ? 2'd0 : lane_q;
        lane_d   = lane_q;
        acc_d    = acc_q;
        if (byte_v) begin
            // Lane counter wraps 3 -> 0 as the word completes.
            lane_d = cur_lane + 2'd1;
            case (cur_lane)
                2'd0:    acc_d[7:0]   = byte_in;
                2'd1:    acc_d[15:8]  = byte_in;
                2'd2:    acc_d[23:16] = byte_in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= 2'd0;
            acc_q  <= 24'd0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end

    assign lanes     = lane_q;
    assign word_rdy  = byte_v && (cur_lane == 2'd3);
    assign word      = {byte_in, acc_q};
    assign part_mask = lane_mask(lane_q);
    // Stale bytes from earlier words may sit in acc_q; mask them out.
    assign part_data = {8'h00, acc_q} & mask_to_bits(part_mask);

endmodule

// File: rtl/rx_udp_packer.sv
// rx_udp_packer: packs the UDP payload stream into 32-bit RX SRAM words,
// reports the frame length and holds the buffer until software releases it.
// Ports: RX_CLK, rst_n (sync, active-low); rx_udp_data_v/rx_udp_data payload;
//   rx_release frees the buffer; mem_we/mem_wmask/mem_addr/mem_wdata SRAM write;
//   rx_done/rx_len/rx_full/rx_ovf frame status; rx_drop_cnt dropped frames.
// Macro RX_PACK_DROP_CNT_EN enables the saturating drop counter (else 0).
module rx_udp_packer
    import vthernet_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 512,
    parameter int LEN_W     = 16
) (
    input  logic              RX_CLK,
    input  logic              rst_n,
    input  logic              rx_udp_data_v,
    input  logic [7:0]        rx_udp_data,
    input  logic              rx_release,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              rx_done,
    output logic [LEN_W-1:0]  rx_len,
    output logic              rx_full,
    output logic              rx_ovf,
    output logic [15:0]       rx_drop_cnt
);

    rx_state_e state_q;
    rx_state_e state_d;

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic              wfull_q;
    logic              wfull_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              rel_q;
    logic              rel_d;
    logic              we_q;
    logic              we_d;
    logic [3:0]        wmask_q;
    logic [3:0]        wmask_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_q;
    logic [31:0]       wdata_d;
    logic              done_q;
    logic              done_d;

    logic        pk_start;
    logic        pk_v;
    logic [1:0]  pk_lanes;
    logic        pk_rdy;
    logic [31:0] pk_word;
    logic [31:0] pk_part;
    logic [3:0]  pk_pmask;
    logic        clr_buf;

    rx_byte_packer u_pack (
        .clk       (RX_CLK),
        .rst_n     (rst_n),
        .start     (pk_start),
        .byte_v    (pk_v),
        .byte_in   (rx_udp_data),
        .lanes     (pk_lanes),
        .word_rdy  (pk_rdy),
        .word      (pk_word),
        .part_data (pk_part),
        .part_mask (pk_pmask)
    );

    // State register
    always_ff @(posedge RX_CLK) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SYNC: begin
                if (!rx_udp_data_v) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rx_udp_data_v) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (!rx_udp_data_v) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (rx_udp_data_v) begin
                    state_d = ST_DROP;
                end else if (rx_release) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!rx_udp_data_v) begin
                    state_d = (rel_q || rx_release) ? ST_IDLE : ST_HOLD;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // Datapath and registered outputs
    always_comb begin
        idx_d   = idx_q;
        wfull_d = wfull_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        rel_d   = rel_q;
        we_d    = 1'b0;
        wmask_d = 4'b0000;
        addr_d  = '0;
        wdata_d = 32'd0;
        done_d  = 1'b0;

        pk_start = (state_q == ST_IDLE);
        pk_v     = rx_udp_data_v &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_RECV) && !wfull_q));

        clr_buf = (state_d == ST_IDLE) &&
                  ((state_q == ST_HOLD) || (state_q == ST_DROP));

        unique case (state_q)
            ST_IDLE: begin
                if (rx_udp_data_v) len_d = LEN_W'(1);
            end
            ST_RECV: begin
                if (rx_udp_data_v) begin
                    // Once every word is written, further bytes are lost.
                    if (wfull_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        len_d = len_q + LEN_W'(1);
                    end
                end else if (pk_lanes != 2'd0) begin
                    we_d    = 1'b1;
                    wmask_d = pk_pmask;
                    addr_d  = idx_q;
                    wdata_d = pk_part;
                end
            end
            ST_FLUSH: begin
                done_d = 1'b1;
            end
            ST_DROP: begin
                if (rx_release) rel_d = 1'b1;
            end
            default: ;
        endcase

        if (pk_rdy) begin
            we_d    = 1'b1;
            wmask_d = FULL_MASK;
            addr_d  = idx_q;
            wdata_d = pk_word;
            idx_d   = idx_q + ADDR_W'(1);
            // Flag rather than compare idx to MAX_WORDS: the index
            // cannot represent MAX_WORDS when it equals 2**ADDR_W.
            if (idx_q == ADDR_W'(MAX_WORDS - 1)) wfull_d = 1'b1;
        end

        if ((state_q == ST_DROP) && (state_d != ST_DROP)) rel_d = 1'b0;

        if (clr_buf) begin
            idx_d   = '0;
            wfull_d = 1'b0;
            len_d   = '0;
            ovf_d   = 1'b0;
            rel_d   = 1'b0;
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (!rst_n) begin
            idx_q   <= '0;
            wfull_q <= 1'b0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            rel_q   <= 1'b0;
            we_q    <= 1'b0;
            wmask_q <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            wfull_q <= wfull_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            rel_q   <= rel_d;
            we_q    <= we_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // Output logic
    always_comb begin
        rx_full   = (state_q == ST_HOLD) || (state_q == ST_DROP);
        mem_we    = we_q;
        mem_wmask = wmask_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rx_done   = done_q;
        rx_len    = len_q;
        rx_ovf    = ovf_q;
    end

`ifdef RX_PACK_DROP_CNT_EN
    logic [15:0] drop_q;
    logic [15:0] drop_d;

    always_comb begin
        drop_d = drop_q;
        if ((state_q == ST_HOLD) && (state_d == ST_DROP) &&
            (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (!rst_n) begin
            drop_q <= 16'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign rx_drop_cnt = drop_q;
`else
    assign rx_drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rx_udp_packer.sv
// tb_rx_udp_packer: directed self-checking bench for rx_udp_packer.
// Runs the DUT with MAX_WORDS = 4 so the overflow case stays short.
module tb_rx_udp_packer;

    logic        RX_CLK = 1'b0;
    logic        rst_n;
    logic        rx_udp_data_v;
    logic [7:0]  rx_udp_data;
    logic        rx_release;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        rx_done;
    logic [15:0] rx_len;
    logic        rx_full;
    logic        rx_ovf;
    logic [15:0] rx_drop_cnt;

`ifdef RX_PACK_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    rx_udp_packer #(
        .ADDR_W    (9),
        .MAX_WORDS (4),
        .LEN_W     (16)
    ) dut (
        .RX_CLK        (RX_CLK),
        .rst_n         (rst_n),
        .rx_udp_data_v (rx_udp_data_v),
        .rx_udp_data   (rx_udp_data),
        .rx_release    (rx_release),
        .mem_we        (mem_we),
        .mem_wmask     (mem_wmask),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .rx_done       (rx_done),
        .rx_len        (rx_len),
        .rx_full       (rx_full),
        .rx_ovf        (rx_ovf),
        .rx_drop_cnt   (rx_drop_cnt)
    );

    always #5 RX_CLK = ~RX_CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int fall_cyc = 0;
    bit done_seen = 1'b0;

    logic [8:0]  wa[$];
    logic [3:0]  wm[$];
    logic [31:0] wd[$];

    always @(posedge RX_CLK) cyc <= cyc + 1;

    always @(negedge RX_CLK) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wm.push_back(mem_wmask);
            wd.push_back(mem_wdata);
        end
        if (rx_done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [8:0] a,
                          input logic [3:0] m, input logic [31:0] d);
        if (i < wa.size()) begin
            check({tag, "_addr"}, 32'(wa[i]), 32'(a));
            check({tag, "_mask"}, 32'(wm[i]), 32'(m));
            check({tag, "_data"}, wd[i], d);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wm.delete();
        wd.delete();
        done_seen = 1'b0;
    endtask

    task automatic send(input int n, input logic [7:0] b0,
                        input logic [7:0] step);
        logic [7:0] b;
        b = b0;
        for (int i = 0; i < n; i++) begin
            @(posedge RX_CLK);
            #1;
            rx_udp_data_v = 1'b1;
            rx_udp_data   = b;
            b = b + step;
        end
        @(posedge RX_CLK);
        #1;
        rx_udp_data_v = 1'b0;
        rx_udp_data   = 8'h00;
        fall_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done_seen && k < 20) begin
            @(negedge RX_CLK);
            k++;
        end
        check(tag, 32'(done_seen), 32'd1);
    endtask

    task automatic release_buf();
        @(posedge RX_CLK);
        #1;
        rx_release = 1'b1;
        @(posedge RX_CLK);
        #1;
        rx_release = 1'b0;
        @(negedge RX_CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        rx_udp_data_v = 1'b0;
        rx_udp_data   = 8'h00;
        rx_release    = 1'b0;
        repeat (3) @(posedge RX_CLK);
        @(negedge RX_CLK);
        check("rst_we",    32'(mem_we),    32'd0);
        check("rst_mask",  32'(mem_wmask), 32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_wdata", mem_wdata,      32'd0);
        check("rst_done",  32'(rx_done),   32'd0);
        check("rst_len",   32'(rx_len),    32'd0);
        check("rst_full",  32'(rx_full),   32'd0);
        check("rst_ovf",   32'(rx_ovf),    32'd0);
        check("rst_drop",  32'(rx_drop_cnt), 32'd0);
        @(posedge RX_CLK);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge RX_CLK);
        clear_log();

        // 8-byte frame 01..08
        send(8, 8'h01, 8'h01);
        wait_done("a_done");
        check("a_lat", 32'(done_cyc - fall_cyc), 32'd2);
        check("a_nwr", 32'(wa.size()), 32'd2);
        chk_wr("a_w0", 0, 9'd0, 4'hF, 32'h04030201);
        chk_wr("a_w1", 1, 9'd1, 4'hF, 32'h08070605);
        check("a_len",  32'(rx_len),  32'd8);
        check("a_full", 32'(rx_full), 32'd1);
        check("a_ovf",  32'(rx_ovf),  32'd0);
        release_buf();
        check("a_rel_full", 32'(rx_full), 32'd0);
        check("a_rel_len",  32'(rx_len),  32'd0);
        clear_log();

        // 5-byte frame AA..EE
        send(5, 8'hAA, 8'h11);
        wait_done("b_done");
        check("b_nwr", 32'(wa.size()), 32'd2);
        chk_wr("b_w0", 0, 9'd0, 4'hF, 32'hDDCCBBAA);
        chk_wr("b_w1", 1, 9'd1, 4'h1, 32'h000000EE);
        check("b_len", 32'(rx_len), 32'd5);
        release_buf();
        clear_log();

        // 1-byte frame
        send(1, 8'h5A, 8'h00);
        wait_done("c_done");
        check("c_nwr", 32'(wa.size()), 32'd1);
        chk_wr("c_w0", 0, 9'd0, 4'h1, 32'h0000005A);
        check("c_len", 32'(rx_len), 32'd1);
        release_buf();
        clear_log();

        // 20-byte frame into a 4-word buffer
        send(20, 8'h10, 8'h01);
        wait_done("o_done");
        check("o_nwr", 32'(wa.size()), 32'd4);
        chk_wr("o_w0", 0, 9'd0, 4'hF, 32'h13121110);
        chk_wr("o_w1", 1, 9'd1, 4'hF, 32'h17161514);
        chk_wr("o_w2", 2, 9'd2, 4'hF, 32'h1B1A1918);
        chk_wr("o_w3", 3, 9'd3, 4'hF, 32'h1F1E1D1C);
        check("o_len", 32'(rx_len), 32'd16);
        check("o_ovf", 32'(rx_ovf), 32'd1);
        release_buf();
        check("o_rel_ovf", 32'(rx_ovf), 32'd0);
        clear_log();

        // Held frame, second frame dropped with release during it
        send(3, 8'h21, 8'h01);
        wait_done("d1_done");
        check("d1_nwr", 32'(wa.size()), 32'd1);
        chk_wr("d1_w0", 0, 9'd0, 4'h7, 32'h00232221);
        clear_log();
        for (int i = 0; i < 4; i++) begin
            @(posedge RX_CLK);
            #1;
            rx_udp_data_v = 1'b1;
            rx_udp_data   = 8'h80 + 8'(i);
            rx_release    = (i == 1);
        end
        @(posedge RX_CLK);
        #1;
        rx_udp_data_v = 1'b0;
        rx_release    = 1'b0;
        @(posedge RX_CLK);
        @(negedge RX_CLK);
        check("d2_nwr",  32'(wa.size()),   32'd0);
        check("d2_full", 32'(rx_full),     32'd0);
        check("d2_len",  32'(rx_len),      32'd0);
        check("d2_drop", 32'(rx_drop_cnt), 32'(DROP_EN));
        clear_log();

        // Frame stored, then back-to-back frame dropped
        send(2, 8'h61, 8'h01);
        send(3, 8'h71, 8'h01);
        wait_done("d3_done");
        @(posedge RX_CLK);
        @(negedge RX_CLK);
        check("d3_nwr", 32'(wa.size()), 32'd1);
        chk_wr("d3_w0", 0, 9'd0, 4'h3, 32'h00006261);
        check("d3_len",  32'(rx_len),      32'd2);
        check("d3_full", 32'(rx_full),     32'd1);
        check("d3_drop", 32'(rx_drop_cnt), 32'(2 * DROP_EN));
        release_buf();
        clear_log();

        // Reset mid-frame, released while data_v still high
        @(posedge RX_CLK);
        #1;
        rx_udp_data_v = 1'b1;
        rx_udp_data   = 8'h90;
        @(posedge RX_CLK);
        #1;
        rx_udp_data = 8'h91;
        rst_n = 1'b0;
        repeat (2) @(posedge RX_CLK);
        @(negedge RX_CLK);
        check("r_drop", 32'(rx_drop_cnt), 32'd0);
        @(posedge RX_CLK);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_udp_data = 8'hA0 + 8'(i);
            @(posedge RX_CLK);
            #1;
        end
        rx_udp_data_v = 1'b0;
        repeat (3) @(posedge RX_CLK);
        @(negedge RX_CLK);
        check("r_nwr",  32'(wa.size()), 32'd0);
        check("r_done", 32'(done_seen), 32'd0);
        clear_log();
        send(4, 8'h11, 8'h11);
        wait_done("r2_done");
        check("r2_nwr", 32'(wa.size()), 32'd1);
        chk_wr("r2_w0", 0, 9'd0, 4'hF, 32'h44332211);
        check("r2_len", 32'(rx_len), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
